// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO in front of a UART transmitter. Writes are queued in a circular
//   buffer; a small drain FSM hands one byte at a time to the transmitter
//   using a TX_LOAD pulse and a LOAD_OK ready/busy handshake.
//
//   Optional build macro: UART_TX_FIFO_CRLF_EN
//     When defined, a queued 0x0A is sent as 0x0D followed by 0x0A.
//     When undefined, every byte is sent verbatim.
//
// Parameters
//   BYTE_W      data byte width
//   DEPTH_LOG2  log2 of FIFO depth
//
// Ports
//   sys_clk   in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   drain enable (only gates starting a new load)
//   WR_EN     in   write strobe, one byte per cycle
//   WR_DATA   in   byte to enqueue
//   FULL      out  registered, occupancy == depth
//   EMPTY     out  registered, occupancy == 0
//   COUNT     out  registered occupancy
//   OVERFLOW  out  sticky, a write was dropped while full
//   LOAD_OK   in   transmitter ready for a byte
//   TX_LOAD   out  one-cycle load pulse to the transmitter
//   TX_DATA   out  byte for the transmitter, held until the next load
module uart_tx_fifo #(
   parameter int BYTE_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  WR_EN,
   input  logic [BYTE_W-1:0]     WR_DATA,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVERFLOW,
   input  logic                  LOAD_OK,
   output logic                  TX_LOAD,
   output logic [BYTE_W-1:0]     TX_DATA
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

`ifdef UART_TX_FIFO_CRLF_EN
   localparam logic [BYTE_W-1:0] LF_BYTE = BYTE_W'(8'h0A);
   localparam logic [BYTE_W-1:0] CR_BYTE = BYTE_W'(8'h0D);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_CR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;
`endif

   logic [BYTE_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg, count_next;
   logic                  full_reg, empty_reg, overflow_reg;
   logic                  tx_load_reg;
   logic [BYTE_W-1:0]     tx_data_reg;
   state_t                state_reg, state_next;
   logic                  seen_low_reg, seen_low_next;
`ifdef UART_TX_FIFO_CRLF_EN
   logic                  lf_pending_reg, lf_pending_next;
`endif

   logic                  wr_accept;
   logic                  pop;
   logic                  issue;
   logic [BYTE_W-1:0]     issue_data;
   logic [BYTE_W-1:0]     head;

   // FULL is the registered flag, so a write in the same cycle as a pop
   // from a full FIFO is still dropped.
   assign wr_accept = WR_EN && !full_reg;
   assign head      = mem[rd_ptr_reg];

   always_comb begin
      state_next    = state_reg;
      seen_low_next = seen_low_reg;
      issue         = 1'b0;
      pop           = 1'b0;
      issue_data    = head;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_next = lf_pending_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (en && LOAD_OK && !empty_reg) begin
               issue         = 1'b1;
               seen_low_next = 1'b0;
               state_next    = ST_LOAD;
`ifdef UART_TX_FIFO_CRLF_EN
               // LF at the head: send CR first and leave the LF queued.
               if (head == LF_BYTE) begin
                  issue_data      = CR_BYTE;
                  lf_pending_next = 1'b1;
               end else begin
                  pop = 1'b1;
               end
`else
               pop = 1'b1;
`endif
            end
         end
         ST_LOAD: begin
            // A low LOAD_OK already in the pulse cycle counts as the
            // transmitter having taken the byte.
            if (!LOAD_OK) seen_low_next = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // Require a low-then-high LOAD_OK so a stale ready level
            // cannot trigger a second load.
            if (!LOAD_OK) begin
               seen_low_next = 1'b1;
            end else if (seen_low_reg) begin
`ifdef UART_TX_FIFO_CRLF_EN
               state_next = lf_pending_reg ? ST_CR : ST_IDLE;
`else
               state_next = ST_IDLE;
`endif
            end
         end
`ifdef UART_TX_FIFO_CRLF_EN
         ST_CR: begin
            // The LF that followed a CR is still at the head; pop it now.
            if (en && LOAD_OK) begin
               issue           = 1'b1;
               pop             = 1'b1;
               seen_low_next   = 1'b0;
               lf_pending_next = 1'b0;
               state_next      = ST_LOAD;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (wr_accept && !pop)
         count_next = count_reg + CNT_ONE;
      else if (!wr_accept && pop)
         count_next = count_reg - CNT_ONE;
   end

   always_ff @(posedge sys_clk) begin
      if (wr_accept && !rst)
         mem[wr_ptr_reg] <= WR_DATA;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         full_reg       <= 1'b0;
         empty_reg      <= 1'b1;
         overflow_reg   <= 1'b0;
         tx_load_reg    <= 1'b0;
         tx_data_reg    <= '0;
         state_reg      <= ST_IDLE;
         seen_low_reg   <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
         lf_pending_reg <= 1'b0;
`endif
      end else begin
         if (wr_accept) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)       rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg    <= count_next;
         full_reg     <= (count_next == CNT_FULL);
         empty_reg    <= (count_next == '0);
         if (WR_EN && full_reg) overflow_reg <= 1'b1;
         tx_load_reg  <= issue;
         if (issue) tx_data_reg <= issue_data;
         state_reg    <= state_next;
         seen_low_reg <= seen_low_next;
`ifdef UART_TX_FIFO_CRLF_EN
         lf_pending_reg <= lf_pending_next;
`endif
      end
   end

   assign FULL     = full_reg;
   assign EMPTY    = empty_reg;
   assign COUNT    = count_reg;
   assign OVERFLOW = overflow_reg;
   assign TX_LOAD  = tx_load_reg;
   assign TX_DATA  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A simple transmitter model drops
//   LOAD_OK for three cycles after every TX_LOAD (auto mode); some tests
//   drive LOAD_OK by hand instead (manual mode). Every TX_LOAD cycle pushes
//   TX_DATA into rx_q, so a stretched or repeated pulse shows up as an
//   extra entry.
module tb_uart_tx_fifo;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       en;
   logic       WR_EN;
   logic [7:0] WR_DATA;
   logic       FULL;
   logic       EMPTY;
   logic [4:0] COUNT;
   logic       OVERFLOW;
   logic       LOAD_OK;
   logic       TX_LOAD;
   logic [7:0] TX_DATA;

   logic       manual_mode;
   logic       load_ok_man;
   logic       load_ok_auto = 1'b1;
   int         busy_cnt = 0;
   logic [7:0] rx_q [$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         base;

   assign LOAD_OK = manual_mode ? load_ok_man : load_ok_auto;

   always #5 sys_clk = ~sys_clk;

   uart_tx_fifo #(.BYTE_W(8), .DEPTH_LOG2(4)) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .en       (en),
      .WR_EN    (WR_EN),
      .WR_DATA  (WR_DATA),
      .FULL     (FULL),
      .EMPTY    (EMPTY),
      .COUNT    (COUNT),
      .OVERFLOW (OVERFLOW),
      .LOAD_OK  (LOAD_OK),
      .TX_LOAD  (TX_LOAD),
      .TX_DATA  (TX_DATA)
   );

   // Transmitter model and capture log.
   always @(negedge sys_clk) begin
      if (TX_LOAD) begin
         rx_q.push_back(TX_DATA);
         busy_cnt = 3;
      end
      load_ok_auto = (busy_cnt == 0);
      if (busy_cnt > 0) busy_cnt--;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("  ok %s = 0x%0h", tag, got);
      end
   endtask

   task automatic settle();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      WR_EN   = 1'b1;
      WR_DATA = d;
      @(posedge sys_clk);
      #1;
      WR_EN   = 1'b0;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      WR_EN = 1'b0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
   endtask

   // Bounded wait for n captured bytes, then a few idle cycles so that any
   // extra load would also be counted.
   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_q.size() < n; i++) tick(1);
      tick(6);
      check_val("rx_count", rx_q.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; WR_EN = 1'b0; WR_DATA = '0;
      manual_mode = 1'b1; load_ok_man = 1'b0;

      // Reset state
      do_reset();
      settle();
      check_val("rst_count",    COUNT, 0);
      check_val("rst_empty",    EMPTY, 1);
      check_val("rst_full",     FULL, 0);
      check_val("rst_overflow", OVERFLOW, 0);
      check_val("rst_tx_load",  TX_LOAD, 0);
      check_val("rst_tx_data",  TX_DATA, 0);

      // Minimum latency, then LOAD_OK held high must not reissue
      en = 1'b1; load_ok_man = 1'b1; base = rx_q.size();
      write_byte(8'h41);
      settle();
      check_val("lat_n1_empty",   EMPTY, 0);
      check_val("lat_n1_count",   COUNT, 1);
      check_val("lat_n1_tx_load", TX_LOAD, 0);
      settle();
      check_val("lat_n2_tx_load", TX_LOAD, 1);
      check_val("lat_n2_tx_data", TX_DATA, 8'h41);
      check_val("lat_n2_count",   COUNT, 0);
      write_byte(8'h42);
      tick(8);
      check_val("stale_one_load", rx_q.size() - base, 1);
      check_val("stale_count",    COUNT, 1);
      load_ok_man = 1'b0;
      tick(1);
      load_ok_man = 1'b1;
      wait_rx(base + 2, 20);
      check_val("stale_byte0", rx_q[base], 8'h41);
      check_val("stale_byte1", rx_q[base+1], 8'h42);

      // Three bytes with a handshaking transmitter
      do_reset();
      manual_mode = 1'b0; en = 1'b1; base = rx_q.size();
      write_byte(8'h41);
      write_byte(8'h42);
      write_byte(8'h43);
      wait_rx(base + 3, 200);
      for (int i = 0; i < 3; i++)
         check_val($sformatf("abc_byte%0d", i), rx_q[base+i], 8'h41 + i);
      settle();
      check_val("abc_empty", EMPTY, 1);

      // Fill past full with the drain disabled, then drain
      do_reset();
      en = 1'b0; base = rx_q.size();
      for (int i = 0; i < 17; i++) write_byte(8'(i));
      settle();
      check_val("fill_full",     FULL, 1);
      check_val("fill_count",    COUNT, 16);
      check_val("fill_overflow", OVERFLOW, 1);
      check_val("fill_no_drain", rx_q.size(), base);
      en = 1'b1;
      wait_rx(base + 16, 400);
      for (int i = 0; i < 16; i++)
         check_val($sformatf("fill_byte%0d", i), rx_q[base+i], i);
      settle();
      check_val("fill_end_empty",    EMPTY, 1);
      check_val("fill_end_overflow", OVERFLOW, 1);

      // Pop and write in the same cycle while full
      do_reset();
      en = 1'b0; manual_mode = 1'b1; load_ok_man = 1'b1; base = rx_q.size();
      for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
      settle();
      check_val("pw_full_before", FULL, 1);
      en = 1'b1;
      write_byte(8'h99);
      settle();
      check_val("pw_count",    COUNT, 15);
      check_val("pw_overflow", OVERFLOW, 1);
      check_val("pw_full",     FULL, 0);
      check_val("pw_tx_load",  TX_LOAD, 1);
      check_val("pw_tx_data",  TX_DATA, 8'h20);
      manual_mode = 1'b0;
      wait_rx(base + 16, 400);
      for (int i = 0; i < 16; i++)
         check_val($sformatf("pw_byte%0d", i), rx_q[base+i], 8'h20 + i);

      // Reset while waiting with bytes queued
      do_reset();
      manual_mode = 1'b1; load_ok_man = 1'b1; en = 1'b0; base = rx_q.size();
      for (int i = 0; i < 5; i++) write_byte(8'h51 + 8'(i));
      en = 1'b1;
      tick(3);
      settle();
      check_val("wr_wait_count", COUNT, 4);
      check_val("wr_wait_loads", rx_q.size(), base + 1);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
      settle();
      check_val("wr_rst_count",   COUNT, 0);
      check_val("wr_rst_empty",   EMPTY, 1);
      check_val("wr_rst_tx_load", TX_LOAD, 0);
      check_val("wr_rst_tx_data", TX_DATA, 0);
      tick(3);
      check_val("wr_rst_no_load", rx_q.size(), base + 1);
      write_byte(8'h77);
      settle();
      settle();
      check_val("wr_idle_tx_load", TX_LOAD, 1);
      check_val("wr_idle_tx_data", TX_DATA, 8'h77);

      // Line feed handling
      do_reset();
      manual_mode = 1'b0; en = 1'b1; base = rx_q.size();
      write_byte(8'h48);
      write_byte(8'h0A);
`ifdef UART_TX_FIFO_CRLF_EN
      wait_rx(base + 3, 200);
      check_val("lf_byte0", rx_q[base],   8'h48);
      check_val("lf_byte1", rx_q[base+1], 8'h0D);
      check_val("lf_byte2", rx_q[base+2], 8'h0A);
`else
      wait_rx(base + 2, 200);
      check_val("lf_byte0", rx_q[base],   8'h48);
      check_val("lf_byte1", rx_q[base+1], 8'h0A);
`endif
      settle();
      check_val("lf_empty", EMPTY, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
